// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one UART TX FIFO between N byte sources.
// It can add an ID header byte to each packet, and it pulses tx_start only when the serial link is idle.
module uart_tx_arbiter #(
  parameter int N      = 4,
  parameter bit ID_HDR = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   ack,
  input  logic           fifo_full,
  input  logic           fifo_empty,
  input  logic           tx_tick,
  output logic           fifo_wr,
  output logic [7:0]     fifo_wdata,
  output logic           tx_start,
  output logic           link_busy
);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t       state, state_nxt;
  logic [N-1:0] grant_nxt;
  logic [2:0]   gidx, gidx_nxt;
  logic [2:0]   last, last_nxt;
  logic [2:0]   pick;
  logic [7:0]   lane;
  logic         req_g;
  logic         last_g;

  // Walk the candidates from farthest to nearest after 'last', so the nearest requester wins.
  always_comb begin
    pick = '0;
    for (int k = N; k >= 1; k--) begin
      for (int j = 0; j < N; j++) begin
        if (req[j] && (((int'(last) + k) % N) == j)) pick = 3'(j);
      end
    end
  end

  always_comb begin
    lane = '0;
    for (int j = 0; j < N; j++) begin
      if (gidx == 3'(j)) lane = req_data[8*j +: 8];
    end
  end

  assign req_g  = |(req & grant);
  assign last_g = |(req_last & grant);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      grant <= '0;
      gidx  <= '0;
      last  <= 3'(N-1);
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      gidx  <= gidx_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    gidx_nxt   = gidx;
    last_nxt   = last;
    ack        = '0;
    fifo_wr    = 1'b0;
    fifo_wdata = '0;
    case (state)
      IDLE: begin
        if (|req) begin
          gidx_nxt = pick;
          for (int j = 0; j < N; j++) grant_nxt[j] = (pick == 3'(j));
          state_nxt = ID_HDR ? HDR : DATA;
        end
      end
      HDR: begin
        if (!fifo_full) begin
          fifo_wr    = 1'b1;
          fifo_wdata = 8'h80 | {5'd0, gidx};
          state_nxt  = DATA;
        end
      end
      DATA: begin
        // A stalled owner keeps the grant; nobody else may cut into its packet.
        if (req_g && !fifo_full) begin
          ack        = req & grant;
          fifo_wr    = 1'b1;
          fifo_wdata = lane;
          if (last_g) begin
            last_nxt  = gidx;
            grant_nxt = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Once started, the transmitter chains FIFO bytes by itself; restart only from true idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_start  <= 1'b0;
      link_busy <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      if (!link_busy && !fifo_empty) begin
        tx_start  <= 1'b1;
        link_busy <= 1'b1;
      end else if (link_busy && tx_tick && fifo_empty) begin
        link_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed table-driven bench for uart_tx_arbiter (N=4, ID_HDR=1).
// Each record holds one cycle's inputs and the outputs expected in that same cycle, before its rising edge.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        fifo_full = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        tx_tick = 1'b0;
  logic        fifo_wr;
  logic [7:0]  fifo_wdata;
  logic        tx_start;
  logic        link_busy;

  int total = 0;
  int bad   = 0;
  int nv    = 0;

  uart_tx_arbiter #(.N(4), .ID_HDR(1'b1)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_last(req_last),
    .grant(grant), .ack(ack), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .tx_tick(tx_tick), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
    .tx_start(tx_start), .link_busy(link_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rq;
    logic [31:0] dat;
    logic [3:0]  rl;
    logic        fl, em, tk;
    logic [3:0]  g, a;
    logic        w;
    logic [7:0]  wd;
    logic        st, bz;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic [3:0] rq, input logic [31:0] dat, input logic [3:0] rl,
                              input logic fl, input logic em, input logic tk,
                              input logic [3:0] g, input logic [3:0] a, input logic w,
                              input logic [7:0] wd, input logic st, input logic bz);
    vec_t v;
    v.rq = rq; v.dat = dat; v.rl = rl; v.fl = fl; v.em = em; v.tk = tk;
    v.g = g; v.a = a; v.w = w; v.wd = wd; v.st = st; v.bz = bz;
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input vec_t v);
    chk({tag, " grant"},      32'(grant),      32'(v.g));
    chk({tag, " ack"},        32'(ack),        32'(v.a));
    chk({tag, " fifo_wr"},    32'(fifo_wr),    32'(v.w));
    chk({tag, " fifo_wdata"}, 32'(fifo_wdata), 32'(v.wd));
    chk({tag, " tx_start"},   32'(tx_start),   32'(v.st));
    chk({tag, " link_busy"},  32'(link_busy),  32'(v.bz));
  endtask

  task automatic run_table();
    foreach (vq[i]) begin
      @(negedge clk);
      req = vq[i].rq; req_data = vq[i].dat; req_last = vq[i].rl;
      fifo_full = vq[i].fl; fifo_empty = vq[i].em; tx_tick = vq[i].tk;
      #1;
      check_all($sformatf("v%0d", nv), vq[i]);
      nv++;
    end
    vq.delete();
  endtask

  vec_t zero_v;

  initial begin
    zero_v = '{rq: 4'h0, dat: 32'h0, rl: 4'h0, fl: 1'b0, em: 1'b1, tk: 1'b0,
               g: 4'h0, a: 4'h0, w: 1'b0, wd: 8'h00, st: 1'b0, bz: 1'b0};
    #3;
    check_all("reset_state", zero_v);
    @(negedge clk);
    reset = 1'b1;

    // Single packet from requester 2: header 82 then 11,22,33; link starts once.
    add(4'b0100, 32'h00110000, 4'b0000, 0, 1, 0,  4'b0000, 4'b0000, 0, 8'h00, 0, 0);
    add(4'b0100, 32'h00110000, 4'b0000, 0, 1, 0,  4'b0100, 4'b0000, 1, 8'h82, 0, 0);
    add(4'b0100, 32'h00110000, 4'b0000, 0, 0, 0,  4'b0100, 4'b0100, 1, 8'h11, 0, 0);
    add(4'b0100, 32'h00220000, 4'b0000, 0, 0, 0,  4'b0100, 4'b0100, 1, 8'h22, 1, 1);
    add(4'b0100, 32'h00330000, 4'b0100, 0, 0, 0,  4'b0100, 4'b0100, 1, 8'h33, 0, 1);
    add(4'b0000, 32'h0,        4'b0000, 0, 0, 0,  4'b0000, 4'b0000, 0, 8'h00, 0, 1);
    // Tick with bytes still queued: no restart, link stays busy.
    add(4'b0000, 32'h0,        4'b0000, 0, 0, 1,  4'b0000, 4'b0000, 0, 8'h00, 0, 1);
    add(4'b0000, 32'h0,        4'b0000, 0, 0, 0,  4'b0000, 4'b0000, 0, 8'h00, 0, 1);
    // Tick with FIFO drained: link goes idle.
    add(4'b0000, 32'h0,        4'b0000, 0, 1, 1,  4'b0000, 4'b0000, 0, 8'h00, 0, 1);
    add(4'b0000, 32'h0,        4'b0000, 0, 1, 0,  4'b0000, 4'b0000, 0, 8'h00, 0, 0);

    // Requesters 0 and 1 together: 80,0A,0B then 81,0C,0D, never interleaved.
    add(4'b0011, 32'h00000C0A, 4'b0000, 0, 1, 0,  4'b0000, 4'b0000, 0, 8'h00, 0, 0);
    add(4'b0011, 32'h00000C0A, 4'b0000, 0, 1, 0,  4'b0001, 4'b0000, 1, 8'h80, 0, 0);
    add(4'b0011, 32'h00000C0A, 4'b0000, 0, 0, 0,  4'b0001, 4'b0001, 1, 8'h0A, 0, 0);
    add(4'b0011, 32'h00000C0B, 4'b0001, 0, 0, 0,  4'b0001, 4'b0001, 1, 8'h0B, 1, 1);
    add(4'b0010, 32'h00000C00, 4'b0000, 0, 0, 0,  4'b0000, 4'b0000, 0, 8'h00, 0, 1);
    add(4'b0010, 32'h00000C00, 4'b0000, 0, 0, 0,  4'b0010, 4'b0000, 1, 8'h81, 0, 1);
    add(4'b0010, 32'h00000C00, 4'b0000, 0, 0, 0,  4'b0010, 4'b0010, 1, 8'h0C, 0, 1);
    add(4'b0010, 32'h00000D00, 4'b0010, 0, 0, 0,  4'b0010, 4'b0010, 1, 8'h0D, 0, 1);
    add(4'b0000, 32'h0,        4'b0000, 0, 0, 0,  4'b0000, 4'b0000, 0, 8'h00, 0, 1);

    // Requester 3 with the FIFO full for 5 cycles mid-packet.
    add(4'b1000, 32'h31000000, 4'b0000, 0, 0, 0,  4'b0000, 4'b0000, 0, 8'h00, 0, 1);
    add(4'b1000, 32'h31000000, 4'b0000, 0, 0, 0,  4'b1000, 4'b0000, 1, 8'h83, 0, 1);
    add(4'b1000, 32'h31000000, 4'b0000, 0, 0, 0,  4'b1000, 4'b1000, 1, 8'h31, 0, 1);
    for (int k = 0; k < 5; k++)
      add(4'b1000, 32'h32000000, 4'b0000, 1, 0, 0, 4'b1000, 4'b0000, 0, 8'h00, 0, 1);
    add(4'b1000, 32'h32000000, 4'b0000, 0, 0, 0,  4'b1000, 4'b1000, 1, 8'h32, 0, 1);
    add(4'b1000, 32'h33000000, 4'b1000, 0, 0, 0,  4'b1000, 4'b1000, 1, 8'h33, 0, 1);
    add(4'b0000, 32'h0,        4'b0000, 0, 0, 0,  4'b0000, 4'b0000, 0, 8'h00, 0, 1);

    // Header write coincides with tick on an empty FIFO; the next write restarts the link once.
    add(4'b0001, 32'h00000055, 4'b0001, 0, 1, 0,  4'b0000, 4'b0000, 0, 8'h00, 0, 1);
    add(4'b0001, 32'h00000055, 4'b0001, 0, 1, 1,  4'b0001, 4'b0000, 1, 8'h80, 0, 1);
    add(4'b0001, 32'h00000055, 4'b0001, 0, 0, 0,  4'b0001, 4'b0001, 1, 8'h55, 0, 0);
    add(4'b0000, 32'h0,        4'b0000, 0, 0, 0,  4'b0000, 4'b0000, 0, 8'h00, 1, 1);
    add(4'b0000, 32'h0,        4'b0000, 0, 0, 0,  4'b0000, 4'b0000, 0, 8'h00, 0, 1);

    // Requester 2 packet, interrupted by reset in its first data cycle.
    add(4'b0100, 32'h00770000, 4'b0000, 0, 0, 0,  4'b0000, 4'b0000, 0, 8'h00, 0, 1);
    add(4'b0100, 32'h00770000, 4'b0000, 0, 0, 0,  4'b0100, 4'b0000, 1, 8'h82, 0, 1);
    add(4'b0100, 32'h00770000, 4'b0000, 0, 0, 0,  4'b0100, 4'b0100, 1, 8'h77, 0, 1);
    run_table();

    #2;
    reset = 1'b0;
    #1;
    zero_v.rq = 4'b0100;
    check_all("async_reset", zero_v);
    @(negedge clk);
    req = '0;
    fifo_empty = 1'b1;
    @(negedge clk);
    reset = 1'b1;

    // All four held with 1-byte packets: rotation 0,1,2,3,0,1 starting from requester 0.
    for (int r = 0; r < 6; r++) begin
      add(4'hF, 32'hA3A2A1A0, 4'hF, 0, 1, 0, 4'h0, 4'h0, 0, 8'h00, 0, 0);
      add(4'hF, 32'hA3A2A1A0, 4'hF, 0, 1, 0, 4'(1 << (r % 4)), 4'h0, 1, 8'h80 | 8'(r % 4), 0, 0);
      add(4'hF, 32'hA3A2A1A0, 4'hF, 0, 1, 0, 4'(1 << (r % 4)), 4'(1 << (r % 4)), 1, 8'hA0 | 8'(r % 4), 0, 0);
    end
    run_table();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
